// File: rtl/seven_seg_mux_driver.sv
// seven_seg_mux_driver: time-multiplexed N-digit common-anode 7-segment driver with frame-synchronous update
// Ports: clk/rst clock and async active-high reset; value/dp_in digit nibbles and decimal points;
// digit_en per-digit enable; load capture strobe; lz_suppress/blank display levels;
// c active-low segments (bit7 dp); an active-low anodes; frame_start pulse on index wrap.
module seven_seg_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic                    lz_suppress,
  input  logic                    blank,
  output logic [7:0]              c,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD    = CW'(GUARD_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [15:0][7:0] SEG = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  typedef enum logic {GUARD_S, ACTIVE_S} state_t;
  state_t                     r_st, w_nst;
  logic [CW-1:0]              r_cnt, w_ncnt;
  logic [IW-1:0]              r_idx, w_nidx;
  logic [NUM_DIGITS-1:0][3:0] r_disp, r_shadow;
  logic [NUM_DIGITS-1:0]      r_dp, r_dp_sh, w_sup;
  logic                       r_pend, w_slot_end, w_wrap, w_lit, w_zero;
  logic [3:0]                 w_nib;
  always_comb begin
    w_slot_end = r_cnt == LAST_CNT;
    w_wrap     = w_slot_end && r_idx == LAST_IDX;
    w_ncnt     = w_slot_end ? '0 : r_cnt + 1'b1;
    w_nidx     = !w_slot_end ? r_idx : w_wrap ? '0 : r_idx + 1'b1;
    w_nst      = w_ncnt < GUARD ? GUARD_S : ACTIVE_S;
    w_zero     = 1'b1;
    w_sup      = '0;
    // running AND from the top digit down: digit i is a leading zero if it and all above are zero
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero   = w_zero && r_disp[i] == 4'h0;
      w_sup[i] = lz_suppress && i != 0 && w_zero;
    end
    w_nib = r_disp[r_idx];
    w_lit = r_st == ACTIVE_S && digit_en[r_idx] && !blank && !w_sup[r_idx];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_st        <= GUARD_CYCLES > 0 ? GUARD_S : ACTIVE_S;
      r_disp      <= '0;
      r_shadow    <= '0;
      r_dp        <= '0;
      r_dp_sh     <= '0;
      r_pend      <= 1'b0;
      frame_start <= 1'b0;
      an          <= '1;
      c           <= 8'hFF;
    end else begin
      r_cnt       <= w_ncnt;
      r_idx       <= w_nidx;
      r_st        <= w_nst;
      frame_start <= w_wrap;
      an          <= w_lit ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      c           <= w_lit ? {~r_dp[r_idx], SEG[w_nib][6:0]} : 8'hFF;
      if (load) begin
        r_shadow <= value;
        r_dp_sh  <= dp_in;
      end
      if (w_wrap) r_pend <= 1'b0;
      else if (load) r_pend <= 1'b1;
      // a load coinciding with the wrap bypasses the shadow so it lands in the new frame
      if (w_wrap && load) begin
        r_disp <= value;
        r_dp   <= dp_in;
      end else if (w_wrap && r_pend) begin
        r_disp <= r_shadow;
        r_dp   <= r_dp_sh;
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// tb_seven_seg_mux_driver: scoreboard bench for seven_seg_mux_driver (4 digits, 8-cycle slots, 2-cycle guard)
module tb_seven_seg_mux_driver;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] value;
  logic [3:0]  dp_in, digit_en;
  logic        load, lz_suppress, blank;
  logic [7:0]  c;
  logic [3:0]  an;
  logic        frame_start;
  typedef struct {int cyc; logic [3:0] an; logic [7:0] c; logic fs;} exp_t;
  exp_t q[$];
  int cyc, errors = 0, checks = 0;
  localparam int BIG = 1 << 30;
  seven_seg_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en), .load(load),
    .lz_suppress(lz_suppress), .blank(blank), .c(c), .an(an), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;
  task automatic check(input string name, input logic [3:0] a, input logic [7:0] cc, input logic f,
                       input logic [3:0] ea, input logic [7:0] ec, input logic ef);
    checks++;
    if ({a, cc, f} !== {ea, ec, ef}) begin
      errors++;
      $display("FAIL %s: got an=%b c=%h fs=%b, expected an=%b c=%h fs=%b", name, a, cc, f, ea, ec, ef);
    end
  endtask
  // Frame f covers output cycles 32f+1..32f+32; slot d occupies eight of them, the first two guarded.
  task automatic push_frame(input int f, input logic [31:0] cs, input logic [3:0] lit, input int last);
    for (int j = 1; j <= 32; j++) begin
      exp_t e;
      int s, d;
      s = j - 1;
      d = s / 8;
      e.cyc = 32 * f + j;
      e.fs  = j == 32;
      if (s % 8 >= 2 && lit[d]) begin
        e.an = ~(4'b0001 << d);
        e.c  = cs[8*d +: 8];
      end else begin
        e.an = 4'hF;
        e.c  = 8'hFF;
      end
      if (e.cyc <= last) q.push_back(e);
    end
  endtask
  task automatic wait_cyc(input int k);
    int t = 0;
    while (cyc != k && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (cyc != k) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: got cyc=%0d, expected %0d", cyc, k);
    end
  endtask
  task automatic do_load(input int e, input logic [15:0] v, input logic [3:0] d);
    wait_cyc(e - 1);
    value = v;
    dp_in = d;
    load  = 1'b1;
    wait_cyc(e);
    load  = 1'b0;
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed: got cyc=%0d, expected entry cyc=%0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check($sformatf("cyc%0d", cyc), an, c, frame_start, e.an, e.c, e.fs);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end
  initial begin
    value = '0; dp_in = '0; digit_en = 4'hF; load = 0; lz_suppress = 0; blank = 0;
    push_frame(0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b1111, BIG);
    push_frame(1, {8'hF9, 8'hA4, 8'h88, 8'h8E}, 4'b1111, BIG);
    push_frame(2, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 4'b1111, BIG);
    push_frame(3, {8'hC0, 8'hC0, 8'hC0, 8'h92}, 4'b1111, BIG);
    push_frame(4, {8'hC0, 8'hC0, 8'h92, 8'hC0}, 4'b0011, BIG);
    push_frame(5, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b0001, BIG);
    push_frame(6, {8'hC0, 8'hC0, 8'hC0, 8'h40}, 4'b1011, BIG);
    push_frame(7, {8'hC0, 8'hC0, 8'hC0, 8'h40}, 4'b1001, BIG);
    push_frame(8, {8'hC0, 8'hC0, 8'hC0, 8'h40}, 4'b1111, 276);
    push_frame(0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b1111, BIG);
    repeat (3) @(negedge clk);
    check("reset", an, c, frame_start, 4'hF, 8'hFF, 1'b0);
    rst = 1'b0;
    do_load(10, 16'h12AF, 4'h0);
    do_load(40, 16'h1111, 4'h0);
    do_load(50, 16'h2222, 4'h0);
    do_load(96, 16'h0005, 4'h0);
    do_load(128, 16'h0050, 4'h0);
    lz_suppress = 1'b1;
    do_load(160, 16'h0000, 4'h0);
    do_load(192, 16'h0000, 4'b0001);
    lz_suppress = 1'b0;
    digit_en = 4'b1011;
    wait_cyc(232);
    blank = 1'b1;
    wait_cyc(240);
    blank = 1'b0;
    wait_cyc(256);
    digit_en = 4'hF;
    wait_cyc(276);
    #2 rst = 1'b1;
    #1 check("rst_mid", an, c, frame_start, 4'hF, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_hold", an, c, frame_start, 4'hF, 8'hFF, 1'b0);
    rst = 1'b0;
    wait_cyc(33);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d unchecked entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
